// File: rtl/bank_scan_if.sv
// Beat bus from the bank scan controller to the cell-state BRAMs.
// Carries centre write strobe/address, neighbour reads and debug coordinates.
interface bank_scan_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                    out_valid;
  logic                    out_ready;
  logic [8:0]              write_enable;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic [8:0]              read_enable;
  logic [9*ADDR_WIDTH-1:0] read_addr;
  logic [15:0]             cell_x;
  logic [15:0]             cell_y;

  modport master (
    output out_valid, write_enable, write_addr,
    output read_enable, read_addr, cell_x, cell_y,
    input  out_ready
  );

  modport slave (
    input  out_valid, write_enable, write_addr,
    input  read_enable, read_addr, cell_x, cell_y,
    output out_ready
  );
endinterface

// File: rtl/bank_scan_controller.sv
// Raster scan of a 9-bank life grid with valid/ready beats and generation count.
// Define CONWAY_TORUS_EN for toroidal edge wrapping; default is bounded edges.
module bank_scan_controller #(
  parameter int WIDTH_BLOCKS  = 2,
  parameter int HEIGHT_BLOCKS = 2,
  parameter int ADDR_WIDTH    = 4,
  parameter int GEN_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_WIDTH-1:0] generation,
  bank_scan_if.master          bus
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] WB       = AW'(WIDTH_BLOCKS);
  localparam logic [AW-1:0] XB_LAST  = AW'(WIDTH_BLOCKS - 1);
  localparam logic [AW-1:0] LAST_ROW =
    AW'((HEIGHT_BLOCKS - 1) * WIDTH_BLOCKS);
  localparam logic [AW-1:0] A_ONE    = AW'(1);

`ifdef CONWAY_TORUS_EN
  localparam logic TORUS = 1'b1;
`else
  localparam logic TORUS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            xp_q, xp_d, yp_q, yp_d;
  logic [AW-1:0]         xb_q, xb_d, rb_q, rb_d;
  logic [15:0]           cx_q, cx_d, cy_q, cy_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [GEN_WIDTH-1:0]  gen_q, gen_d;
  logic [8:0]            we_q, we_d, re_q, re_d;
  logic [AW-1:0]         wa_q, wa_d;
  logic [9*AW-1:0]       ra_q, ra_d;

  logic                  accept, last_x, last_y;
  logic [1:0]            xp_inc, yp_inc;
  logic [3:0]            bank_idx;
  logic [AW-1:0]         col_blk [3];
  logic                  col_ok  [3];
  logic [AW-1:0]         row_off [3];
  logic                  row_ok  [3];

  assign accept = valid_q & bus.out_ready;
  assign last_x = (xp_q == 2'd2) && (xb_q == XB_LAST);
  assign last_y = (yp_q == 2'd2) && (rb_q == LAST_ROW);

  always_comb begin
    state_d = state_q;
    xp_d    = xp_q;
    yp_d    = yp_q;
    xb_d    = xb_q;
    rb_d    = rb_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    gen_d   = gen_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          valid_d = 1'b1;
          xp_d = '0; yp_d = '0; xb_d = '0; rb_d = '0;
          cx_d = '0; cy_d = '0;
        end
      end
      SCAN: begin
        if (accept) begin
          if (last_x && last_y) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            gen_d   = gen_q + 1'b1;
            xp_d = '0; yp_d = '0; xb_d = '0; rb_d = '0;
            cx_d = '0; cy_d = '0;
          end else if (last_x) begin
            xp_d = '0; xb_d = '0; cx_d = '0;
            cy_d = cy_q + 16'd1;
            if (yp_q == 2'd2) begin
              yp_d = '0;
              rb_d = rb_q + WB;
            end else begin
              yp_d = yp_q + 2'd1;
            end
          end else begin
            cx_d = cx_q + 16'd1;
            if (xp_q == 2'd2) begin
              xp_d = '0;
              xb_d = xb_q + A_ONE;
            end else begin
              xp_d = xp_q + 2'd1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Each bank column/row sees exactly one of the three neighbours.
  assign xp_inc = (xp_d == 2'd2) ? 2'd0 : xp_d + 2'd1;
  assign yp_inc = (yp_d == 2'd2) ? 2'd0 : yp_d + 2'd1;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      col_blk[i] = xb_d;
      col_ok[i]  = 1'b1;
      if (2'(i) == xp_d) begin
        col_blk[i] = xb_d;
      end else if (2'(i) == xp_inc) begin
        if (xp_d == 2'd2) begin
          if (xb_d == XB_LAST) begin
            col_blk[i] = '0;
            col_ok[i]  = TORUS;
          end else begin
            col_blk[i] = xb_d + A_ONE;
          end
        end
      end else if (xp_d == 2'd0) begin
        if (xb_d == '0) begin
          col_blk[i] = XB_LAST;
          col_ok[i]  = TORUS;
        end else begin
          col_blk[i] = xb_d - A_ONE;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      row_off[i] = rb_d;
      row_ok[i]  = 1'b1;
      if (2'(i) == yp_d) begin
        row_off[i] = rb_d;
      end else if (2'(i) == yp_inc) begin
        if (yp_d == 2'd2) begin
          if (rb_d == LAST_ROW) begin
            row_off[i] = '0;
            row_ok[i]  = TORUS;
          end else begin
            row_off[i] = rb_d + WB;
          end
        end
      end else if (yp_d == 2'd0) begin
        if (rb_d == '0) begin
          row_off[i] = LAST_ROW;
          row_ok[i]  = TORUS;
        end else begin
          row_off[i] = rb_d - WB;
        end
      end
    end
  end

  assign bank_idx = {1'b0, yp_d, 1'b0} + {2'b00, yp_d}
                  + {2'b00, xp_d};

  always_comb begin
    we_d = '0;
    wa_d = '0;
    re_d = '0;
    ra_d = '0;
    if (valid_d) begin
      we_d = 9'(1) << bank_idx;
      wa_d = rb_d + xb_d;
      for (int by = 0; by < 3; by++) begin
        for (int bx = 0; bx < 3; bx++) begin
          if (row_ok[by] && col_ok[bx]) begin
            re_d[by*3+bx] = 1'b1;
            ra_d[(by*3+bx)*AW +: AW] = row_off[by] + col_blk[bx];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xp_q    <= '0;
      yp_q    <= '0;
      xb_q    <= '0;
      rb_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      gen_q   <= '0;
      we_q    <= '0;
      wa_q    <= '0;
      re_q    <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      xp_q    <= xp_d;
      yp_q    <= yp_d;
      xb_q    <= xb_d;
      rb_q    <= rb_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      gen_q   <= gen_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      re_q    <= re_d;
      ra_q    <= ra_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign generation       = gen_q;
  assign bus.out_valid    = valid_q;
  assign bus.write_enable = we_q;
  assign bus.write_addr   = wa_q;
  assign bus.read_enable  = re_q;
  assign bus.read_addr    = ra_q;
  assign bus.cell_x       = cx_q;
  assign bus.cell_y       = cy_q;

endmodule
